cnt1_stream: RTL

- Next-generation popcount pre-stage for the Tanimoto datapath.
- Accepts a fingerprint as SUB_VECTOR_NO consecutive BUS_WIDTH-wide beats.
- Computes the total set-bit count through a registered granule popcount and adder tree, then a per-vector accumulator.
- Forwards each beat, delay-matched, to the downstream intersection stage together with its index. Supports gapped input and a synchronous clear.

---
 rtl/cnt1_stream_pkg.sv | 43 ++++
 rtl/cnt1_stream_if.sv | 43 ++++
 rtl/cnt1_stream_granule.sv | 53 +++++
 rtl/cnt1_stream.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cnt1_stream_pkg.sv
// ============================================================================
// Module : cnt1_pkg
// Brief  : Shared widths and helpers for the cnt1_stream popcount pre-stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cnt1_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int granule_no(input int bw, input int gw);
    return (bw + gw - 1) / gw;
  endfunction

  // Index port keeps at least one bit even for single-beat fingerprints.
  function automatic int idx_w(input int svn);
    return (svn > 1) ? clog2(svn) : 1;
  endfunction

  localparam int BUS_WIDTH_DEF     = 128;
  localparam int SUB_VECTOR_NO_DEF = 2;
  localparam int GRANULE_WIDTH_DEF = 6;

  localparam int GRANULE_NO = granule_no(BUS_WIDTH_DEF, GRANULE_WIDTH_DEF);
  localparam int BEAT_CNT_W = clog2(BUS_WIDTH_DEF + 1);
  localparam int CNT_W      = clog2(BUS_WIDTH_DEF * SUB_VECTOR_NO_DEF + 1);
  localparam int IDX_W      = idx_w(SUB_VECTOR_NO_DEF);
  localparam int LATENCY    = 3;

endpackage

`default_nettype wire

// File: rtl/cnt1_stream_if.sv
// ============================================================================
// Module : cnt1_stream_if
// Brief  : Beat input / delayed beat + count output bundle of cnt1_stream.
//          Carries i_Last and o_Err when CNT1_STREAM_LAST_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cnt1_stream_if
  import cnt1_pkg::*;
#(
  parameter int BUS_WIDTH     = BUS_WIDTH_DEF,
  parameter int SUB_VECTOR_NO = SUB_VECTOR_NO_DEF
);
  localparam int IW = idx_w(SUB_VECTOR_NO);
  localparam int CW = clog2(BUS_WIDTH * SUB_VECTOR_NO + 1);

  logic [BUS_WIDTH-1:0] i_Vector;
  logic                 i_Valid;
  logic                 i_Clear;
  logic [BUS_WIDTH-1:0] o_SubVector;
  logic                 o_SubValid;
  logic [IW-1:0]        o_SubIdx;
  logic [CW-1:0]        o_Cnt;
  logic                 o_CntValid;
`ifdef CNT1_STREAM_LAST_EN
  logic                 i_Last;
  logic                 o_Err;

  modport slave  (input  i_Vector, i_Valid, i_Clear, i_Last,
                  output o_SubVector, o_SubValid, o_SubIdx, o_Cnt, o_CntValid, o_Err);
  modport master (output i_Vector, i_Valid, i_Clear, i_Last,
                  input  o_SubVector, o_SubValid, o_SubIdx, o_Cnt, o_CntValid, o_Err);
`else
  modport slave  (input  i_Vector, i_Valid, i_Clear,
                  output o_SubVector, o_SubValid, o_SubIdx, o_Cnt, o_CntValid);
  modport master (output i_Vector, i_Valid, i_Clear,
                  input  o_SubVector, o_SubValid, o_SubIdx, o_Cnt, o_CntValid);
`endif

endinterface

`default_nettype wire

// File: rtl/cnt1_stream_granule.sv
// ============================================================================
// Module : cnt1_granule
// Brief  : Registered popcount of one GRANULE_WIDTH-bit granule, built from
//          3-bit case-table lookups.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cnt1_granule
  import cnt1_pkg::*;
#(
  parameter int GRANULE_WIDTH = GRANULE_WIDTH_DEF,
  localparam int CW = clog2(GRANULE_WIDTH + 1)
) (
  input  wire logic                     clk,
  input  wire logic                     rstn,
  input  wire logic [GRANULE_WIDTH-1:0] i_bits,
  output logic      [CW-1:0]            o_count
);
  localparam int CHUNKS = (GRANULE_WIDTH + 2) / 3;

  function automatic logic [1:0] pop3(input logic [2:0] b);
    case (b)
      3'b000:                 pop3 = 2'd0;
      3'b001, 3'b010, 3'b100: pop3 = 2'd1;
      3'b011, 3'b101, 3'b110: pop3 = 2'd2;
      default:                pop3 = 2'd3;
    endcase
  endfunction

  logic [CHUNKS*3-1:0] bits_pad;
  logic [CW-1:0]       count_d;
  logic [CW-1:0]       count_q;

  always_comb begin
    bits_pad                   = '0;
    bits_pad[GRANULE_WIDTH-1:0] = i_bits;
    count_d                    = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      count_d = count_d + CW'(pop3(bits_pad[c*3 +: 3]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/cnt1_stream.sv
// ============================================================================
// Module : cnt1_stream
// Brief  : Streaming fingerprint popcount (granule LUTs, adder tree, per-vector
//          accumulator) with a delay-matched beat forward path. Optional early
//          termination via i_Last / o_Err under CNT1_STREAM_LAST_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cnt1_stream
  import cnt1_pkg::*;
#(
  parameter int BUS_WIDTH     = BUS_WIDTH_DEF,
  parameter int SUB_VECTOR_NO = SUB_VECTOR_NO_DEF,
  parameter int GRANULE_WIDTH = GRANULE_WIDTH_DEF
) (
  input wire logic    clk,
  input wire logic    rstn,
  cnt1_stream_if.slave bus
);
  localparam int GNO    = granule_no(BUS_WIDTH, GRANULE_WIDTH);
  localparam int GCW    = clog2(GRANULE_WIDTH + 1);
  localparam int BEAT_W = clog2(BUS_WIDTH + 1);
  localparam int CW     = clog2(BUS_WIDTH * SUB_VECTOR_NO + 1);
  localparam int IW     = idx_w(SUB_VECTOR_NO);

  logic                        take, at_end, term;
  logic [GNO*GRANULE_WIDTH-1:0] vec_pad;
  logic [GCW-1:0]              gcnt [GNO];
  logic [BEAT_W-1:0]           sum_d;
  logic [CW-1:0]               total;

  logic [IW-1:0]        idx_d,       idx_q;
  logic                 s1_valid_d,  s1_valid_q, s1_last_d, s1_last_q;
  logic [IW-1:0]        s1_idx_q;
  logic [BUS_WIDTH-1:0] s1_vec_q;
  logic                 s2_valid_d,  s2_valid_q, s2_last_q;
  logic [IW-1:0]        s2_idx_q;
  logic [BUS_WIDTH-1:0] s2_vec_q;
  logic [BEAT_W-1:0]    s2_sum_q;
  logic [CW-1:0]        acc_d,       acc_q, cnt_d, cnt_q;
  logic                 cnt_valid_d, cnt_valid_q, sub_valid_d, sub_valid_q;
  logic [IW-1:0]        sub_idx_q;
  logic [BUS_WIDTH-1:0] sub_vec_q;
`ifdef CNT1_STREAM_LAST_EN
  logic                 s1_err_d, s1_err_q, s2_err_q, err_d, err_q;
`endif

  always_comb begin
    vec_pad                  = '0;
    vec_pad[BUS_WIDTH-1:0]   = bus.i_Vector;
  end

  for (genvar g = 0; g < GNO; g++) begin : g_gran
    cnt1_granule #(.GRANULE_WIDTH(GRANULE_WIDTH)) u_gran (
      .clk    (clk),
      .rstn   (rstn),
      .i_bits (vec_pad[g*GRANULE_WIDTH +: GRANULE_WIDTH]),
      .o_count(gcnt[g])
    );
  end

  always_comb begin
    take   = bus.i_Valid && !bus.i_Clear;
    at_end = (idx_q == IW'(SUB_VECTOR_NO - 1));
`ifdef CNT1_STREAM_LAST_EN
    term     = at_end || bus.i_Last;
    s1_err_d = at_end && !bus.i_Last;
`else
    term     = at_end;
`endif
    idx_d = idx_q;
    if (bus.i_Clear)  idx_d = '0;
    else if (take)    idx_d = term ? '0 : idx_q + IW'(1);

    s1_valid_d = take;
    s1_last_d  = term;

    sum_d = '0;
    for (int g = 0; g < GNO; g++) begin
      sum_d = sum_d + BEAT_W'(gcnt[g]);
    end
    s2_valid_d = s1_valid_q && !bus.i_Clear;

    // Clear kills whatever S3 would have produced this edge, o_Cnt stays put.
    total       = acc_q + CW'(s2_sum_q);
    sub_valid_d = s2_valid_q && !bus.i_Clear;
    cnt_valid_d = sub_valid_d && s2_last_q;
    cnt_d       = cnt_valid_d ? total : cnt_q;
    acc_d       = acc_q;
    if (bus.i_Clear)     acc_d = '0;
    else if (s2_valid_q) acc_d = s2_last_q ? '0 : total;
`ifdef CNT1_STREAM_LAST_EN
    err_d = cnt_valid_d && s2_err_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_idx_q    <= '0;
      s1_vec_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_idx_q    <= '0;
      s2_vec_q    <= '0;
      s2_sum_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      cnt_valid_q <= 1'b0;
      sub_valid_q <= 1'b0;
      sub_idx_q   <= '0;
      sub_vec_q   <= '0;
`ifdef CNT1_STREAM_LAST_EN
      s1_err_q    <= 1'b0;
      s2_err_q    <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_idx_q    <= idx_q;
      s1_vec_q    <= bus.i_Vector;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s1_last_q;
      s2_idx_q    <= s1_idx_q;
      s2_vec_q    <= s1_vec_q;
      s2_sum_q    <= sum_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      cnt_valid_q <= cnt_valid_d;
      sub_valid_q <= sub_valid_d;
      sub_idx_q   <= s2_idx_q;
      sub_vec_q   <= s2_vec_q;
`ifdef CNT1_STREAM_LAST_EN
      s1_err_q    <= s1_err_d;
      s2_err_q    <= s1_err_q;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.o_SubVector = sub_vec_q;
  assign bus.o_SubValid  = sub_valid_q;
  assign bus.o_SubIdx    = sub_idx_q;
  assign bus.o_Cnt       = cnt_q;
  assign bus.o_CntValid  = cnt_valid_q;
`ifdef CNT1_STREAM_LAST_EN
  assign bus.o_Err       = err_q;
`endif

endmodule

`default_nettype wire
